input_load: RTL and testbench

- Reader counterpart of the output store path.
- Fetches 128-bit words from the shared buffer RAM, starting at one of two half-bank bases, and unpacks each word into a byte stream of 16 bytes for the compute pipeline.
- Byte order is most-significant byte first, matching the store side's packing order.
- Sits between the buffer RAM read port and the pipeline's byte input, with a valid/ready handshake on the byte side.

---
 rtl/input_load_pkg.sv | 21 ++
 rtl/word_unpacker.sv | 53 +++++
 rtl/input_load.sv | 101 ++++++++++
 tb/tb_input_load.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_load_pkg.sv
// Shared definitions for the buffer-RAM load/store paths: FSM states, word
// geometry and the half-bank base address helper.
package input_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 16;
  localparam int WORD_W         = 128;

  // Half-bank base: offset bit selects the upper or lower half of the RAM.
  function automatic logic [15:0] base_address(input logic offset);
    return {offset, 15'b0};
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Holds one 128-bit word and hands it out MSB-first, one byte per accept.
// Handshake: a byte transfers on a cycle where byte_valid and byte_ready are both 1;
// byte_out/last_out stay put while byte_valid=1 and byte_ready=0.
module word_unpacker
  import input_load_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              clear,
  input  logic              last_word,
  input  logic              byte_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic              last_out,
  output logic              word_consumed
);

  logic [WORD_W-1:0] shift_q;
  logic [3:0]        idx_q;
  logic              valid_q;
  logic              accept;
  logic              final_byte;

  assign accept     = valid_q & byte_ready;
  assign final_byte = (idx_q == 4'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= load_word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (accept) begin
      shift_q <= shift_q << 8;
      idx_q   <= idx_q + 4'd1;
      if (final_byte) valid_q <= 1'b0;
    end
  end

  assign byte_out      = shift_q[WORD_W-1 -: 8];
  assign byte_valid    = valid_q;
  assign last_out      = valid_q & last_word & final_byte;
  assign word_consumed = accept & final_byte;

endmodule

// File: rtl/input_load.sv
// Reads WordCount 128-bit words from the buffer RAM starting at a half-bank base
// and streams them out as bytes, one word request at a time (no prefetch).
module input_load
  import input_load_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              StartIn,
  input  logic              input_base_offset,
  input  logic [15:0]       WordCount,
  output logic [ADDR_W-1:0] ReadAddress,
  output logic              ReadEnable,
  input  logic [WORD_W-1:0] ReadBus,
  output logic [7:0]        ByteOut,
  output logic              ByteValid,
  input  logic              ByteReady,
  output logic              LastOut,
  output logic              Done,
  output state_t            fsm_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wc_q;
  logic [15:0]       words_done_q;
  logic [2:0]        lat_q;
  logic              capture;
  logic              word_consumed;
  logic              last_word;
  logic              run_complete;

  // Data is on ReadBus during the READ_LATENCY-th cycle after the REQ cycle.
  assign capture      = (state_q == WAIT) && (lat_q == 3'(READ_LATENCY - 1)) && StartIn;
  assign last_word    = (words_done_q == wc_q - 16'd1);
  assign run_complete = (words_done_q + 16'd1 == wc_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (StartIn) state_d = (WordCount == 16'd0) ? DONE : REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (capture) state_d = STREAM;
      STREAM:  if (word_consumed) state_d = run_complete ? DONE : REQ;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Dropping StartIn aborts from anywhere.
    if (!StartIn) state_d = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wc_q         <= '0;
      words_done_q <= '0;
      lat_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          addr_q       <= ADDR_W'(base_address(input_base_offset));
          words_done_q <= '0;
          if (StartIn) wc_q <= WordCount;
        end
        REQ:  lat_q <= '0;
        WAIT: lat_q <= lat_q + 3'd1;
        STREAM: begin
          if (word_consumed) begin
            words_done_q <= words_done_q + 16'd1;
            if (!run_complete) addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  word_unpacker u_unpacker (
    .clock         (clock),
    .reset         (reset),
    .load          (capture),
    .load_word     (ReadBus),
    .clear         (!StartIn),
    .last_word     (last_word),
    .byte_ready    (ByteReady),
    .byte_out      (ByteOut),
    .byte_valid    (ByteValid),
    .last_out      (LastOut),
    .word_consumed (word_consumed)
  );

  assign ReadAddress = addr_q;
  assign ReadEnable  = (state_q == REQ);
  assign Done        = (state_q == DONE);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_input_load.sv
// Bench for input_load: two instances (READ_LATENCY 1 and 3), a latency-accurate
// RAM model per instance, a byte/address scoreboard built from the word list.
module tb_input_load;
  import input_load_pkg::*;

  localparam int N = 2;

  logic         clock;
  logic         reset;
  logic         start_in   [N];
  logic         base_off   [N];
  logic [15:0]  word_count [N];
  logic [15:0]  read_addr  [N];
  logic         read_en    [N];
  logic [7:0]   byte_out   [N];
  logic         byte_valid [N];
  logic         byte_ready [N];
  logic         last_out   [N];
  logic         done       [N];
  state_t       fsm        [N];

  logic [127:0] mem [int];
  logic [8:0]   exp_q [$];
  logic [15:0]  addr_eq [$];
  int           n_pass = 0;
  int           n_total = 0;

  function automatic logic [127:0] word_at(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {a, ~a, a, ~a, a, ~a, a, ~a};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and RAM models ----------------
  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [127:0] pipe   [L];
    logic         pipe_v [L];
    logic [127:0] rbus;

    input_load #(.READ_LATENCY(L), .ADDR_W(16)) dut (
      .clock             (clock),
      .reset             (reset),
      .StartIn           (start_in[g]),
      .input_base_offset (base_off[g]),
      .WordCount         (word_count[g]),
      .ReadAddress       (read_addr[g]),
      .ReadEnable        (read_en[g]),
      .ReadBus           (rbus),
      .ByteOut           (byte_out[g]),
      .ByteValid         (byte_valid[g]),
      .ByteReady         (byte_ready[g]),
      .LastOut           (last_out[g]),
      .Done              (done[g]),
      .fsm_state         (fsm[g])
    );

    always @(posedge clock) begin
      pipe[0]   <= word_at(read_addr[g]);
      pipe_v[0] <= read_en[g];
      for (int k = 1; k < L; k++) begin
        pipe[k]   <= pipe[k-1];
        pipe_v[k] <= pipe_v[k-1];
      end
    end
    // Junk outside the one valid cycle exposes a mistimed capture.
    assign rbus = pipe_v[L-1] ? pipe[L-1] : {4{32'hDEAD_BEEF}};
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic build_model(input int start, input int wc);
    exp_q.delete();
    addr_eq.delete();
    for (int w = 0; w < wc; w++) begin
      int a;
      logic [127:0] word;
      a = (start + w) % 65536;
      if (!mem.exists(a)) mem[a] = {$urandom, $urandom, $urandom, $urandom};
      word = mem[a];
      addr_eq.push_back(16'(a));
      for (int b = 0; b < 16; b++) begin
        logic [7:0] by;
        by = 8'(word >> (8 * (15 - b)));
        exp_q.push_back({(w == wc - 1) && (b == 15), by});
      end
    end
  endtask

  task automatic check_all_zero(input int g, input string tag);
    check({tag, "_addr"},  read_addr[g], 16'h0);
    check({tag, "_ren"},   read_en[g], 1'b0);
    check({tag, "_byte"},  byte_out[g], 8'h0);
    check({tag, "_valid"}, byte_valid[g], 1'b0);
    check({tag, "_last"},  last_out[g], 1'b0);
    check({tag, "_done"},  done[g], 1'b0);
    check({tag, "_state"}, fsm[g], IDLE);
  endtask

  // ---------------- driver ----------------
  // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random.
  task automatic run_case(input int g, input logic off, input int wc, input int mode,
                          input int abort_after, input bit do_force,
                          output int reads, output int bytes, output logic [15:0] first_addr);
    int   since, req_cyc;
    bit   prev_stall, prev_valid, fin, forced;
    logic [7:0] prev_byte;
    logic prev_last, r;
    build_model(do_force ? 16'hFFFF : (off ? 32768 : 0), wc);
    reads = 0; bytes = 0; first_addr = '0;
    since = 100; req_cyc = 0; prev_stall = 0; prev_valid = 0; fin = 0; forced = do_force;
    prev_byte = '0; prev_last = 0;
    @(negedge clock);
    base_off[g] = off; word_count[g] = 16'(wc); start_in[g] = 1'b1; byte_ready[g] = 1'b0;
    if (do_force) force gen_dut[0].dut.addr_q = 16'hFFFF;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clock);
      since++;
      if (forced && fsm[g] == WAIT) begin
        release gen_dut[0].dut.addr_q;
        forced = 0;
      end
      if (abort_after >= 0 && bytes == abort_after) begin
        start_in[g] = 1'b0; byte_ready[g] = 1'b0;
        @(negedge clock);
        check("abort_valid", byte_valid[g], 1'b0);
        check("abort_done",  done[g], 1'b0);
        check("abort_ren",   read_en[g], 1'b0);
        check("abort_last",  last_out[g], 1'b0);
        check("abort_state", fsm[g], IDLE);
        fin = 1;
      end else begin
        if (read_en[g]) begin
          if (reads == 0) first_addr = read_addr[g];
          reads++;
          req_cyc = cyc;
          if (addr_eq.size() > 0) check("read_addr", read_addr[g], addr_eq.pop_front());
          else check("extra_read", 1'b1, 1'b0);
          // Mid-run changes must be ignored.
          word_count[g] = 16'($urandom_range(0, 9));
          base_off[g] = ~base_off[g];
        end
        if (prev_stall) begin
          check("stall_valid", byte_valid[g], 1'b1);
          check("stall_byte",  byte_out[g], prev_byte);
          check("stall_last",  last_out[g], prev_last);
        end
        if (byte_valid[g] && !prev_valid) check("capture_latency", cyc - req_cyc, lat_of(g) + 1);
        if (!byte_valid[g]) check("last_without_valid", last_out[g], 1'b0);
        prev_valid = byte_valid[g];
        if (done[g]) begin
          check("done_valid", byte_valid[g], 1'b0);
          if (wc > 0) check("done_gap", since, 1);
          start_in[g] = 1'b0;
          @(negedge clock);
          check("done_release", done[g], 1'b0);
          check("idle_after_done", fsm[g], IDLE);
          fin = 1;
        end else begin
          r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
          byte_ready[g] = r;
          if (byte_valid[g] && r) begin
            if (mode == 0 && bytes % 16 != 0) check("consecutive", since, 1);
            if (exp_q.size() > 0) check("byte_last", {last_out[g], byte_out[g]}, exp_q.pop_front());
            else check("extra_byte", 1'b1, 1'b0);
            bytes++;
            since = 0;
          end
          prev_stall = byte_valid[g] && !r;
          prev_byte  = byte_out[g];
          prev_last  = last_out[g];
        end
      end
    end
    if (!fin) check("timeout", 1'b0, 1'b1);
    byte_ready[g] = 1'b0;
  endtask

  task automatic reset_mid_wait(input int g);
    int waited;
    @(negedge clock);
    base_off[g] = 1'b0; word_count[g] = 16'd2; start_in[g] = 1'b1; byte_ready[g] = 1'b1;
    waited = 0;
    while (fsm[g] != WAIT && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("reach_wait", fsm[g], WAIT);
    if (lat_of(g) > 1) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_all_zero(g, "mid_reset");
    start_in[g] = 1'b0; byte_ready[g] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic        off;
    int          wc;
    int          mode;
    int          exp_reads;
    int          exp_bytes;
    logic [15:0] exp_first;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int reads, bytes;
    logic [15:0] first;

    vecs[0] = '{1'b0, 1, 0, 1, 16, 16'h0000};
    vecs[1] = '{1'b1, 3, 0, 3, 48, 16'h8000};
    vecs[2] = '{1'b0, 2, 1, 2, 32, 16'h0000};
    vecs[3] = '{1'b1, 3, 2, 3, 48, 16'h8000};
    vecs[4] = '{1'b0, 0, 0, 0, 0,  16'h0000};

    mem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    reset = 1'b1;
    for (int g = 0; g < N; g++) begin
      start_in[g] = 1'b0; base_off[g] = 1'b0; word_count[g] = '0; byte_ready[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < N; g++) check_all_zero(g, "por");
    repeat (3) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_case(0, vecs[i].off, vecs[i].wc, vecs[i].mode, -1, 0, reads, bytes, first);
      check($sformatf("v%0d_reads", i), reads, vecs[i].exp_reads);
      check($sformatf("v%0d_bytes", i), bytes, vecs[i].exp_bytes);
      if (vecs[i].exp_reads > 0) check($sformatf("v%0d_first", i), first, vecs[i].exp_first);
      check($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
    end

    // Abort after byte 5 of word 2 of 4, then restart from the base.
    run_case(0, 1'b0, 4, 0, 21, 0, reads, bytes, first);
    check("abort_bytes", bytes, 21);
    check("abort_reads", reads, 2);
    run_case(0, 1'b0, 1, 0, -1, 0, reads, bytes, first);
    check("restart_first", first, 16'h0000);
    check("restart_bytes", bytes, 16);

    // Address wrap from 0xFFFF.
    run_case(0, 1'b0, 2, 0, -1, 1, reads, bytes, first);
    check("wrap_first", first, 16'hFFFF);
    check("wrap_reads", reads, 2);
    check("wrap_sb_empty", exp_q.size(), 0);

    // Latency sweep with reset asserted mid-WAIT.
    for (int g = 0; g < N; g++) begin
      reset_mid_wait(g);
      run_case(g, 1'b1, 2, 2, -1, 0, reads, bytes, first);
      check($sformatf("lat%0d_first", lat_of(g)), first, 16'h8000);
      check($sformatf("lat%0d_bytes", lat_of(g)), bytes, 32);
      check($sformatf("lat%0d_sb_empty", lat_of(g)), exp_q.size(), 0);
    end
    run_case(1, 1'b0, 1, 1, -1, 0, reads, bytes, first);
    check("lat3_single_bytes", bytes, 16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
